// File: rtl/systolic_ws_drain.sv
// systolic_ws_drain: result drain buffer for the weight-stationary array.
// Optional output register: define SYSTOLIC_WS_DRAIN_OUTREG_EN.
module systolic_ws_drain #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROW_NUM        = 8,
  parameter int COL_NUM        = 8,
  parameter int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      row_wr_en   [0:COL_NUM-1],
  input  logic [ROW_ADDR_WIDTH-1:0] row_wraddr  [0:COL_NUM-1],
  input  logic [DATA_WIDTH-1:0]     row_data_in [0:COL_NUM-1],
  output logic                      val_out,
  input  logic                      rdy_out,
  output logic [DATA_WIDTH-1:0]     data_out    [0:COL_NUM-1],
  output logic [ROW_ADDR_WIDTH-1:0] row_idx_out,
  output logic                      last_out,
  output logic                      busy,
  output logic                      done,
  output logic                      err_overwrite
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW =
    ROW_ADDR_WIDTH'(ROW_NUM - 1);

  logic [DATA_WIDTH-1:0]     mem      [ROW_NUM][COL_NUM];
  logic [COL_NUM-1:0]        fill     [ROW_NUM];
  logic [COL_NUM-1:0]        fill_nxt [ROW_NUM];
  logic [ROW_ADDR_WIDTH-1:0] rd_row;
  logic                      head_full;
  logic                      pop;
  logic                      accept;
  logic                      any_wr;
  logic                      ovw;
  state_t                    state;
  state_t                    state_nxt;

  assign head_full = &fill[rd_row];
  assign accept    = val_out && rdy_out;

  // Fill-bit update: head clear on pop first, then column writes set.
  always_comb begin
    ovw    = 1'b0;
    any_wr = 1'b0;
    for (int r = 0; r < ROW_NUM; r++) begin
      fill_nxt[r] = fill[r];
    end
    if (pop) begin
      fill_nxt[rd_row] = '0;
    end
    for (int c = 0; c < COL_NUM; c++) begin
      if (row_wr_en[c]) begin
        any_wr = 1'b1;
        if (fill[row_wraddr[c]][c] &&
            !(pop && row_wraddr[c] == rd_row)) begin
          ovw = 1'b1;
        end
        fill_nxt[row_wraddr[c]][c] = 1'b1;
      end
    end
  end

  // Fill bits, head pointer and sticky overwrite flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        fill[r] <= '0;
      end
      rd_row        <= '0;
      err_overwrite <= 1'b0;
    end else begin
      for (int r = 0; r < ROW_NUM; r++) begin
        fill[r] <= fill_nxt[r];
      end
      if (pop) begin
        rd_row <= (rd_row == LAST_ROW) ? '0 : rd_row + 1'b1;
      end
      if (ovw) begin
        err_overwrite <= 1'b1;
      end
    end
  end

  // Result storage; validity is tracked by the fill bits alone.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COL_NUM; c++) begin
      if (row_wr_en[c]) begin
        mem[row_wraddr[c]][c] <= row_data_in[c];
      end
    end
  end

`ifdef SYSTOLIC_WS_DRAIN_OUTREG_EN
  // Head row leaves the buffer when the output slot is free or draining.
  assign pop = head_full && (!val_out || rdy_out);

  // One-entry output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_out     <= 1'b0;
      row_idx_out <= '0;
      last_out    <= 1'b0;
      for (int c = 0; c < COL_NUM; c++) begin
        data_out[c] <= '0;
      end
    end else if (pop) begin
      val_out     <= 1'b1;
      row_idx_out <= rd_row;
      last_out    <= (rd_row == LAST_ROW);
      for (int c = 0; c < COL_NUM; c++) begin
        data_out[c] <= mem[rd_row][c];
      end
    end else if (rdy_out) begin
      val_out <= 1'b0;
    end
  end
`else
  assign pop = accept;

  // Head row presented directly; payload zeroed while nothing is valid.
  always_comb begin
    val_out     = head_full;
    row_idx_out = rd_row;
    last_out    = head_full && (rd_row == LAST_ROW);
    for (int c = 0; c < COL_NUM; c++) begin
      data_out[c] = head_full ? mem[rd_row][c] : '0;
    end
  end
`endif

  // Job state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job sequencing: idle until a write, done after the last row leaves.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_wr) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        busy = 1'b1;
        if (accept && last_out) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = any_wr ? S_ACTIVE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_systolic_ws_drain.sv
// tb_systolic_ws_drain: directed jobs with a scoreboard on the row stream.
// Expected rows are queued at scheduling time and checked by a monitor.
module tb_systolic_ws_drain;

  localparam int DW = 16;
  localparam int RN = 4;
  localparam int CN = 4;
  localparam int AW = 2;
  localparam int NT = 2048;
`ifdef SYSTOLIC_WS_DRAIN_OUTREG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic          clk;
  logic          reset;
  logic          row_wr_en   [0:CN-1];
  logic [AW-1:0] row_wraddr  [0:CN-1];
  logic [DW-1:0] row_data_in [0:CN-1];
  logic          val_out;
  logic          rdy_out;
  logic [DW-1:0] data_out    [0:CN-1];
  logic [AW-1:0] row_idx_out;
  logic          last_out;
  logic          busy;
  logic          done;
  logic          err_overwrite;

  systolic_ws_drain #(
    .DATA_WIDTH(DW),
    .ROW_NUM(RN),
    .COL_NUM(CN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_wr_en(row_wr_en),
    .row_wraddr(row_wraddr),
    .row_data_in(row_data_in),
    .val_out(val_out),
    .rdy_out(rdy_out),
    .data_out(data_out),
    .row_idx_out(row_idx_out),
    .last_out(last_out),
    .busy(busy),
    .done(done),
    .err_overwrite(err_overwrite)
  );

  typedef struct {
    int                idx;
    logic [CN-1:0][DW-1:0] d;
    bit                last;
    int                cyc;
  } exp_t;

  exp_t q[$];

  logic          tw_en [0:NT-1][0:CN-1];
  logic [AW-1:0] tw_ad [0:NT-1][0:CN-1];
  logic [DW-1:0] tw_d  [0:NT-1][0:CN-1];
  logic          trdy  [0:NT-1];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int T;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic put(int t, int c, int r, logic [DW-1:0] d);
    tw_en[t][c] = 1'b1;
    tw_ad[t][c] = r[AW-1:0];
    tw_d[t][c]  = d;
  endtask

  // Skewed job: column c writes row r at t0+c+r; writes at or after
  // 'upto' are dropped; one cell may be moved to cycle skip_t.
  task automatic job(int t0, int base, int upto,
                     int skip_r, int skip_c, int skip_t);
    for (int r = 0; r < RN; r++) begin
      for (int c = 0; c < CN; c++) begin
        int t;
        t = (r == skip_r && c == skip_c) ? skip_t : t0 + c + r;
        if (t < upto) put(t, c, r, DW'(base + 16 * r + c));
      end
    end
  endtask

  task automatic exp_rows(int base, int c0, int ov_r, logic [DW-1:0] ov_d);
    for (int r = 0; r < RN; r++) begin
      exp_t e;
      e.idx  = r;
      e.last = (r == RN - 1);
      e.cyc  = (c0 < 0) ? -1 : c0 + r;
      for (int c = 0; c < CN; c++) e.d[c] = DW'(base + 16 * r + c);
      if (r == ov_r) e.d[0] = ov_d;
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    T = cyc;
  endtask

  task automatic at(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  // Table-driven input driver, updated just after each rising edge.
  initial begin
    rdy_out = 1'b1;
    for (int c = 0; c < CN; c++) begin
      row_wr_en[c]   = 1'b0;
      row_wraddr[c]  = '0;
      row_data_in[c] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (cyc < NT) begin
        rdy_out = trdy[cyc];
        for (int c = 0; c < CN; c++) begin
          row_wr_en[c]   = tw_en[cyc][c];
          row_wraddr[c]  = tw_ad[cyc][c];
          row_data_in[c] = tw_d[cyc][c];
        end
      end
    end
  end

  // Monitor: compare accepted rows against the scoreboard.
  initial begin
    bit          pstall;
    logic [AW-1:0] pidx;
    pstall = 1'b0;
    pidx   = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (pstall && !reset) begin
        chk("hold_val", val_out, 1'b1);
        chk("hold_idx", row_idx_out, pidx);
      end
      pstall = val_out && !rdy_out && !reset;
      pidx   = row_idx_out;
      if (val_out && rdy_out) begin
        if (q.size() == 0) begin
          chk("unexpected_row", 32'(row_idx_out), 32'hffff_ffff);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("row_idx", row_idx_out, e.idx);
          chk("last", last_out, e.last);
          for (int c = 0; c < CN; c++) begin
            chk($sformatf("r%0d_d%0d", e.idx, c), data_out[c], e.d[c]);
          end
          if (e.cyc >= 0) chk("emit_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    for (int t = 0; t < NT; t++) begin
      trdy[t] = 1'b1;
      for (int c = 0; c < CN; c++) begin
        tw_en[t][c] = 1'b0;
        tw_ad[t][c] = '0;
        tw_d[t][c]  = '0;
      end
    end
    reset = 1'b1;

    // 1: skewed job, no backpressure
    do_reset();
    d0 = done_cnt;
    job(T + 10, 0, NT, -1, 0, 0);
    exp_rows(0, T + 14 + XL, -1, '0);
    at(T + 1);
    chk("rst_val", val_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_overwrite, 1'b0);
    chk("rst_last", last_out, 1'b0);
    chk("rst_idx", row_idx_out, '0);
    chk("rst_d0", data_out[0], '0);
    at(T + 13 + XL);
    chk("s1_val_pre", val_out, 1'b0);
    at(T + 17 + XL);
    chk("s1_busy17", busy, 1'b1);
    chk("s1_done17", done, 1'b0);
    at(T + 18 + XL);
    chk("s1_done18", done, 1'b1);
    chk("s1_busy18", busy, 1'b0);
    at(T + 19 + XL);
    chk("s1_done19", done, 1'b0);
    at(T + 30);
    chk("s1_q_empty", q.size(), 0);
    chk("s1_done_cnt", done_cnt - d0, 1);

    // 2: backpressure until cycle 30
    do_reset();
    for (int t = T; t < T + 30; t++) trdy[t] = 1'b0;
    job(T + 10, 5, NT, -1, 0, 0);
    exp_rows(5, T + 30, -1, '0);
    at(T + 14 + XL);
    chk("s2_val14", val_out, 1'b1);
    chk("s2_idx14", row_idx_out, 2'd0);
    at(T + 29);
    chk("s2_val29", val_out, 1'b1);
    chk("s2_idx29", row_idx_out, 2'd0);
    at(T + 40);
    chk("s2_q_empty", q.size(), 0);
    chk("s2_err", err_overwrite, 1'b0);

    // 3: row 0 column 2 withheld until cycle 25
    do_reset();
    job(T + 10, 32, NT, 0, 2, T + 25);
    exp_rows(32, T + 26 + XL, -1, '0);
    at(T + 25 + XL);
    chk("s3_val25", val_out, 1'b0);
    at(T + 40);
    chk("s3_q_empty", q.size(), 0);
    chk("s3_err", err_overwrite, 1'b0);

    // 4: column 0 rewrites row 2 before it is popped
    do_reset();
    job(T + 10, 0, NT, -1, 0, 0);
    put(T + 12, 0, 2, 16'h11);
    put(T + 14, 0, 2, 16'h22);
    exp_rows(0, T + 14 + XL, 2, 16'h22);
    at(T + 14);
    chk("s4_err14", err_overwrite, 1'b0);
    at(T + 15);
    chk("s4_err15", err_overwrite, 1'b1);
    at(T + 40);
    chk("s4_err_sticky", err_overwrite, 1'b1);
    chk("s4_q_empty", q.size(), 0);

    // 5: reset at cycle 12 mid-job, then a fresh job
    do_reset();
    job(T + 10, 64, T + 12, -1, 0, 0);
    at(T + 11);
    chk("s5_busy11", busy, 1'b1);
    at(T + 12);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("s5_rst_val", val_out, 1'b0);
    chk("s5_rst_busy", busy, 1'b0);
    chk("s5_rst_idx", row_idx_out, '0);
    chk("s5_rst_d1", data_out[1], '0);
    chk("s5_rst_err", err_overwrite, 1'b0);
    do_reset();
    job(T + 10, 256, NT, -1, 0, 0);
    exp_rows(256, T + 14 + XL, -1, '0);
    at(T + 30);
    chk("s5_q_empty", q.size(), 0);
    chk("s5_err", err_overwrite, 1'b0);

    // 6: second job starts in the DONE cycle
    do_reset();
    d0 = done_cnt;
    job(T + 10, 0, NT, -1, 0, 0);
    exp_rows(0, T + 14 + XL, -1, '0);
    job(T + 18 + XL, 512, NT, -1, 0, 0);
    exp_rows(512, T + 22 + 2 * XL, -1, '0);
    at(T + 18 + XL);
    chk("s6_doneA", done, 1'b1);
    at(T + 19 + XL);
    chk("s6_busyB", busy, 1'b1);
    at(T + 26 + 2 * XL);
    chk("s6_doneB", done, 1'b1);
    at(T + 40);
    chk("s6_q_empty", q.size(), 0);
    chk("s6_done_cnt", done_cnt - d0, 2);
    chk("s6_err", err_overwrite, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
